// File: rtl/ibex_xif_imem_pkg.sv
// ============================================================================
// Module  : ibex_xif_imem_pkg
// Brief   : Shared response type and address helpers for the Ibex fetch responder.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ibex_xif_imem_pkg;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } imem_resp_t;

    // Word offset of a byte address relative to the store base; the caller
    // truncates to its index width, so out-of-window addresses wrap.
    function automatic logic [29:0] imem_word_offset(input logic [31:0] addr,
                                                     input logic [31:0] base);
        return 30'((addr - base) >> 2);
    endfunction

    function automatic logic imem_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input logic [31:0] words);
        return (33'(addr - base)) < (33'(words) << 2);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ibex_xif_imem_if.sv
// ============================================================================
// Module  : ibex_xif_imem_if
// Brief   : Ibex instruction fetch bus (req/gnt/addr -> rvalid/rdata/err).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface ibex_xif_imem_if;
    logic        instr_req;
    logic        instr_gnt;
    logic [31:0] instr_addr;
    logic        instr_rvalid;
    logic [31:0] instr_rdata;
    logic        instr_err;

    modport master (
        output instr_req,
        output instr_addr,
        input  instr_gnt,
        input  instr_rvalid,
        input  instr_rdata,
        input  instr_err
    );

    modport slave (
        input  instr_req,
        input  instr_addr,
        output instr_gnt,
        output instr_rvalid,
        output instr_rdata,
        output instr_err
    );
endinterface

`default_nettype wire

// File: rtl/ibex_xif_imem_resp_pipe.sv
// ============================================================================
// Module  : ibex_xif_imem_resp_pipe
// Brief   : Latency-stage valid + response delay line; the last stage is the retire point.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ibex_xif_imem_resp_pipe
    import ibex_xif_imem_pkg::*;
#(
    parameter int unsigned Latency = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       in_valid_i,
    input  imem_resp_t in_resp_i,
    output logic       out_valid_o,
    output imem_resp_t out_resp_o
);

    logic [Latency-1:0] valid_q;
    logic [Latency-1:0] valid_d;
    imem_resp_t         resp_q [Latency];
    imem_resp_t         resp_d [Latency];

    always_comb begin
        valid_d    = '0;
        resp_d     = resp_q;
        valid_d[0] = in_valid_i;
        resp_d[0]  = in_resp_i;
        for (int i = 1; i < int'(Latency); i++) begin
            valid_d[i] = valid_q[i-1];
            resp_d[i]  = resp_q[i-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            resp_q  <= '{default: '0};
        end else begin
            valid_q <= valid_d;
            resp_q  <= resp_d;
        end
    end

    assign out_valid_o = valid_q[Latency-1];
    assign out_resp_o  = resp_q[Latency-1];

endmodule

`default_nettype wire

// File: rtl/ibex_xif_imem_responder.sv
// ============================================================================
// Module  : ibex_xif_imem_responder
// Brief   : Fixed-latency, in-order instruction memory responder for the Ibex fetch bus.
//           Define IBEX_XIF_IMEM_RANGE_CHECK_EN to flag out-of-window fetches with err.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ibex_xif_imem_responder
    import ibex_xif_imem_pkg::*;
#(
    parameter int unsigned  MemWords       = 1024,
    parameter logic [31:0]  BaseAddr       = 32'h0000_0000,
    parameter int unsigned  Latency        = 2,
    parameter int unsigned  MaxOutstanding = 2,
    localparam int unsigned AW             = $clog2(MemWords),
    localparam int unsigned CW             = $clog2(MaxOutstanding + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    ibex_xif_imem_if.slave  bus,
    input  logic            stall_i,
    input  logic            wr_en_i,
    input  logic [AW-1:0]   wr_addr_i,
    input  logic [31:0]     wr_data_i,
    output logic [CW-1:0]   outstanding_o
);

    localparam logic [CW-1:0] MaxCnt = CW'(MaxOutstanding);

    logic [31:0]   mem_q [MemWords];
    logic [AW-1:0] rd_idx;
    imem_resp_t    rd_resp;
    imem_resp_t    out_resp;
    logic          gnt;
    logic          retire;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign rd_idx = AW'(imem_word_offset(bus.instr_addr, BaseAddr));

    // Combinational read sees pre-edge contents, giving read-before-write.
    always_comb begin
        rd_resp = '0;
`ifdef IBEX_XIF_IMEM_RANGE_CHECK_EN
        if (imem_in_range(bus.instr_addr, BaseAddr, 32'(MemWords))) begin
            rd_resp.rdata = mem_q[rd_idx];
        end else begin
            rd_resp.err = 1'b1;
        end
`else
        rd_resp.rdata = mem_q[rd_idx];
`endif
    end

    // A retiring response frees its slot in the same cycle.
    always_comb begin
        gnt = 1'b0;
        if (bus.instr_req && !stall_i && !rst_i && ((cnt_q < MaxCnt) || retire)) begin
            gnt = 1'b1;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (gnt && !retire) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!gnt && retire) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i && !rst_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    ibex_xif_imem_resp_pipe #(
        .Latency (Latency)
    ) u_resp_pipe (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (gnt),
        .in_resp_i   (rd_resp),
        .out_valid_o (retire),
        .out_resp_o  (out_resp)
    );

    assign bus.instr_gnt    = gnt;
    assign bus.instr_rvalid = retire;
    assign bus.instr_err    = retire & out_resp.err;
    assign bus.instr_rdata  = (retire && !out_resp.err) ? out_resp.rdata : 32'h0;
    assign outstanding_o    = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_ibex_xif_imem_responder.sv
// ============================================================================
// Module  : tb_ibex_xif_imem_responder
// Brief   : Two responder configurations (Lat2/Max2 and Lat3/Max1) against a cycle reference model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ibex_xif_imem_responder;

    localparam int unsigned A_WORDS = 16;
    localparam int unsigned B_WORDS = 8;
    localparam int unsigned A_LAT   = 2;
    localparam int unsigned B_LAT   = 3;
    localparam int          A_MAXO  = 2;
    localparam int          B_MAXO  = 1;
    localparam logic [31:0] A_BASE  = 32'h0000_0000;
    localparam logic [31:0] B_BASE  = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        stall;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [1:0]  a_outst;
    logic [0:0]  b_outst;

    always #5 clk = ~clk;

    ibex_xif_imem_if ifa ();
    ibex_xif_imem_if ifb ();

    assign ifa.instr_req  = req;
    assign ifa.instr_addr = addr;
    assign ifb.instr_req  = req;
    assign ifb.instr_addr = addr;

    ibex_xif_imem_responder #(
        .MemWords(A_WORDS), .BaseAddr(A_BASE), .Latency(A_LAT), .MaxOutstanding(A_MAXO)
    ) u_dut_a (
        .clk_i(clk), .rst_i(rst), .bus(ifa), .stall_i(stall), .wr_en_i(wr_en),
        .wr_addr_i(wr_addr), .wr_data_i(wr_data), .outstanding_o(a_outst)
    );

    ibex_xif_imem_responder #(
        .MemWords(B_WORDS), .BaseAddr(B_BASE), .Latency(B_LAT), .MaxOutstanding(B_MAXO)
    ) u_dut_b (
        .clk_i(clk), .rst_i(rst), .bus(ifb), .stall_i(stall), .wr_en_i(wr_en),
        .wr_addr_i(wr_addr[2:0]), .wr_data_i(wr_data), .outstanding_o(b_outst)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: shadow store plus a table of responses due at a given cycle.
    logic [31:0] mem   [2][16];
    bit          due_v [2][64];
    logic [31:0] due_d [2][64];
    bit          due_e [2][64];
    int          inflight [2];
    int          peak     [2];
    int          cyc      = 0;
    bit          model_on = 1'b0;

    task automatic model_step(input int d, input logic g, input logic v,
                              input logic [31:0] rd, input logic e, input int outs);
        int unsigned words = (d == 0) ? A_WORDS : B_WORDS;
        int unsigned lat   = (d == 0) ? A_LAT   : B_LAT;
        int          maxo  = (d == 0) ? A_MAXO  : B_MAXO;
        logic [31:0] base  = (d == 0) ? A_BASE  : B_BASE;
        int          slot  = cyc % 64;
        bit          retire = due_v[d][slot];
        bit          exp_g;
        logic [31:0] off;
        int unsigned idx;
        logic [31:0] dat;
        bit          er;
        int          dslot;

        exp_g = req && !stall && ((inflight[d] < maxo) || retire);
        check_eq($sformatf("gnt[%0d]", d),    32'(g),    32'(exp_g));
        check_eq($sformatf("rvalid[%0d]", d), 32'(v),    32'(retire));
        check_eq($sformatf("rdata[%0d]", d),  rd,        retire ? due_d[d][slot] : 32'h0);
        check_eq($sformatf("err[%0d]", d),    32'(e),    retire ? 32'(due_e[d][slot]) : 32'h0);
        check_eq($sformatf("outst[%0d]", d),  32'(outs), 32'(inflight[d]));

        if (retire) begin
            due_v[d][slot] = 1'b0;
            inflight[d]--;
        end
        if (exp_g) begin
            off = addr - base;
            idx = (off >> 2) % words;
            dat = mem[d][idx];
            er  = 1'b0;
`ifdef IBEX_XIF_IMEM_RANGE_CHECK_EN
            if (!({32'h0, off} < 64'(words) * 64'd4)) begin
                dat = 32'h0;
                er  = 1'b1;
            end
`endif
            dslot = (cyc + int'(lat)) % 64;
            due_v[d][dslot] = 1'b1;
            due_d[d][dslot] = dat;
            due_e[d][dslot] = er;
            inflight[d]++;
            if (inflight[d] > peak[d]) peak[d] = inflight[d];
        end
        if (wr_en) mem[d][wr_addr % words] = wr_data;
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (model_on) begin
                check_eq("gnt_rst[0]", 32'(ifa.instr_gnt), 32'h0);
                check_eq("gnt_rst[1]", 32'(ifb.instr_gnt), 32'h0);
            end
            model_on = 1'b1;
            for (int d = 0; d < 2; d++) begin
                inflight[d] = 0;
                for (int s = 0; s < 64; s++) due_v[d][s] = 1'b0;
            end
        end else if (model_on) begin
            model_step(0, ifa.instr_gnt, ifa.instr_rvalid, ifa.instr_rdata, ifa.instr_err, int'(a_outst));
            model_step(1, ifb.instr_gnt, ifb.instr_rvalid, ifb.instr_rdata, ifb.instr_err, int'(b_outst));
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req   = 1'b0;
        stall = 1'b0;
        wr_en = 1'b0;
        repeat (n) step();
    endtask

    int g_a;
    int g_b;

    initial begin
        rst = 1'b1; req = 1'b0; stall = 1'b0; wr_en = 1'b0;
        wr_addr = '0; addr = '0; wr_data = '0;
        peak[0] = 0; peak[1] = 0;
        repeat (3) step();
        @(negedge clk);
        check_eq("rst_rvalid_a", 32'(ifa.instr_rvalid), 32'h0);
        check_eq("rst_outst_a",  32'(a_outst),          32'h0);
        step();
        rst = 1'b0;

        // Preload; low words last so both stores hold 11/22/33/44 at words 0..3.
        for (int i = 4; i < 16; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = $urandom; step();
        end
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1; wr_addr = 4'(i); wr_data = 32'h11 * (i + 1); step();
        end
        idle(2);

        // Single fetch of word 0.
        req = 1'b1; addr = 32'h0;
        @(negedge clk);
        check_eq("t1_gnt", 32'(ifa.instr_gnt), 32'h1);
        step();
        req = 1'b0;
        step();
        @(negedge clk);
        check_eq("t1_rvalid", 32'(ifa.instr_rvalid), 32'h1);
        check_eq("t1_rdata",  ifa.instr_rdata,       32'h11);
        idle(6);

        // Back-to-back fetches.
        peak[0] = 0;
        req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr = 32'(4 * i); step();
        end
        idle(8);
        check_eq("t2_peak_a", 32'(peak[0]), 32'd2);

        // Continuous request window from idle.
        peak[1] = 0; g_a = 0; g_b = 0;
        req = 1'b1; addr = B_BASE + 32'h4;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            g_a += int'(ifa.instr_gnt);
            g_b += int'(ifb.instr_gnt);
            step();
        end
        idle(8);
        check_eq("t3_gnts_a", 32'(g_a),     32'd12);
        check_eq("t3_gnts_b", 32'(g_b),     32'd4);
        check_eq("t3_peak_b", 32'(peak[1]), 32'd1);

        // Stall under request.
        g_a = 0;
        req = 1'b1; stall = 1'b1; addr = 32'h8;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            g_a += int'(ifa.instr_gnt) + int'(ifb.instr_gnt);
            step();
        end
        check_eq("t4_stall_gnts", 32'(g_a), 32'd0);
        stall = 1'b0;
        @(negedge clk);
        check_eq("t4_release_gnt", 32'(ifa.instr_gnt), 32'h1);
        step();
        idle(8);

        // Fetch one past the window.
        req = 1'b1; addr = A_BASE + 32'(A_WORDS * 4);
        step();
        req = 1'b0;
        step();
        @(negedge clk);
        check_eq("t5_oor_rvalid", 32'(ifa.instr_rvalid), 32'h1);
`ifdef IBEX_XIF_IMEM_RANGE_CHECK_EN
        check_eq("t5_oor_err",   32'(ifa.instr_err), 32'h1);
        check_eq("t5_oor_rdata", ifa.instr_rdata,    32'h0);
`else
        check_eq("t5_oor_err",   32'(ifa.instr_err), 32'h0);
        check_eq("t5_oor_rdata", ifa.instr_rdata,    32'h11);
`endif
        idle(6);

        // Same-cycle write and read of word 1.
        req = 1'b1; addr = 32'h4; wr_en = 1'b1; wr_addr = 4'd1; wr_data = 32'hAA;
        step();
        req = 1'b0; wr_en = 1'b0;
        step();
        @(negedge clk);
        check_eq("t5_rbw_old", ifa.instr_rdata, 32'h22);
        idle(4);
        req = 1'b1; addr = 32'h4;
        step();
        req = 1'b0;
        step();
        @(negedge clk);
        check_eq("t5_rbw_new", ifa.instr_rdata, 32'hAA);
        idle(6);

        // Reset with requests in flight.
        req = 1'b1; addr = 32'h8;
        step();
        step();
        req = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0;
        g_a = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            g_a += int'(ifa.instr_rvalid) + int'(ifb.instr_rvalid);
            if (i == 0) check_eq("t6_outst_a", 32'(a_outst), 32'h0);
            step();
        end
        check_eq("t6_no_rvalid", 32'(g_a), 32'd0);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            int sel;
            rst   = ($urandom_range(0, 99) == 0);
            req   = ($urandom_range(0, 99) < 70);
            stall = ($urandom_range(0, 99) < 15);
            sel   = int'($urandom_range(0, 9));
            if (sel < 5)      addr = A_BASE + 32'($urandom_range(0, 71));
            else if (sel < 9) addr = B_BASE + 32'($urandom_range(0, 39));
            else              addr = $urandom;
            wr_en   = ($urandom_range(0, 99) < 20);
            wr_addr = 4'($urandom);
            wr_data = $urandom;
            step();
        end
        rst = 1'b0;
        idle(8);
        check_eq("peak_bound_a", 32'(peak[0] <= A_MAXO), 32'h1);
        check_eq("peak_bound_b", 32'(peak[1] <= B_MAXO), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
